off_core_access_arbiter: RTL and testbench

Arbitrates the instruction-fetch and data-access miss paths inside `pumpkin_cpu_top` onto the single off-core access port that connects to main memory. It latches one request at a time and drives the off-core address, valid and write-direction signals. It returns the off-core payload to the granted requester as a one-cycle ready strobe. Round-robin grant gives neither requester starvation, and a watchdog counter flags a memory port that never responds.

---
 rtl/off_core_access_arbiter.sv | 116 +++++++++++
 tb/tb_off_core_access_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/off_core_access_arbiter.sv
// Round-robin arbiter putting instruction and data miss requests onto one off-core port.
// One request is in flight at a time; a sticky watchdog flags a memory port that never answers.
module off_core_access_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [ADDR_WIDTH-1:0] inst_addr_in,
  input  logic                  inst_addr_valid_in,
  output logic [DATA_WIDTH-1:0] inst_payload_out,
  output logic                  inst_ready_out,
  input  logic [ADDR_WIDTH-1:0] data_addr_in,
  input  logic                  data_addr_valid_in,
  input  logic                  data_is_write_in,
  input  logic [DATA_WIDTH-1:0] data_write_payload_in,
  output logic [DATA_WIDTH-1:0] data_payload_out,
  output logic                  data_ready_out,
  output logic [ADDR_WIDTH-1:0] off_core_addr_out,
  output logic                  off_core_addr_valid_out,
  output logic                  off_core_is_write_out,
  output logic [DATA_WIDTH-1:0] off_core_write_payload_out,
  input  logic [DATA_WIDTH-1:0] off_core_payload_in,
  input  logic                  off_core_ready_in,
  output logic                  timeout_error_out
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  // grant_data_q doubles as the round-robin history: it is the last grant made.
  logic                  grant_data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  is_write_q;
  logic [DATA_WIDTH-1:0] wpay_q;
  logic [DATA_WIDTH-1:0] inst_pay_q;
  logic [DATA_WIDTH-1:0] data_pay_q;
  logic [CntW-1:0]       wdog_q;
  logic                  timeout_q;

  logic start;
  logic pick_data;

  assign start     = (state_q == StIdle) && (inst_addr_valid_in || data_addr_valid_in);
  assign pick_data = data_addr_valid_in && (!inst_addr_valid_in || !grant_data_q);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StWait;
      StWait:  if (off_core_ready_in) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      grant_data_q <= 1'b1;
      addr_q       <= '0;
      is_write_q   <= 1'b0;
      wpay_q       <= '0;
      inst_pay_q   <= '0;
      data_pay_q   <= '0;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (start) begin
        grant_data_q <= pick_data;
        addr_q       <= pick_data ? data_addr_in : inst_addr_in;
        is_write_q   <= pick_data && data_is_write_in;
        wpay_q       <= pick_data ? data_write_payload_in : '0;
        wdog_q       <= '0;
      end
      if (state_q == StWait) begin
        if (wdog_q != CntW'(TIMEOUT_CYCLES)) begin
          wdog_q <= wdog_q + CntW'(1);
        end
        if (wdog_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          timeout_q <= 1'b1;
        end
        if (off_core_ready_in) begin
          if (grant_data_q) begin
            data_pay_q <= off_core_payload_in;
          end else begin
            inst_pay_q <= off_core_payload_in;
          end
        end
      end
    end
  end

  always_comb begin
    off_core_addr_valid_out    = (state_q == StWait);
    inst_ready_out             = (state_q == StResp) && !grant_data_q;
    data_ready_out             = (state_q == StResp) && grant_data_q;
    off_core_addr_out          = addr_q;
    off_core_is_write_out      = is_write_q;
    off_core_write_payload_out = wpay_q;
    inst_payload_out           = inst_pay_q;
    data_payload_out           = data_pay_q;
    timeout_error_out          = timeout_q;
  end

endmodule

// File: tb/tb_off_core_access_arbiter.sv
// Directed bench for off_core_access_arbiter: stimulus pushes expected off-core requests and
// requester responses into queues; monitors pop and compare whenever the DUT presents them.
module tb_off_core_access_arbiter;

  typedef struct {
    logic [63:0]  addr;
    logic         w;
    logic [127:0] wp;
  } req_t;

  typedef struct {
    logic         is_data;
    logic [127:0] pay;
  } resp_t;

  logic         clk = 1'b0;
  logic         reset_in = 1'b1;
  logic [63:0]  inst_addr_in = '0;
  logic         inst_addr_valid_in = 1'b0;
  logic [127:0] inst_payload_out;
  logic         inst_ready_out;
  logic [63:0]  data_addr_in = '0;
  logic         data_addr_valid_in = 1'b0;
  logic         data_is_write_in = 1'b0;
  logic [127:0] data_write_payload_in = '0;
  logic [127:0] data_payload_out;
  logic         data_ready_out;
  logic [63:0]  off_core_addr_out;
  logic         off_core_addr_valid_out;
  logic         off_core_is_write_out;
  logic [127:0] off_core_write_payload_out;
  logic [127:0] off_core_payload_in = '0;
  logic         off_core_ready_in = 1'b0;
  logic         timeout_error_out;

  int total = 0;
  int bad = 0;
  int inst_seen = 0;
  int data_seen = 0;

  req_t         exp_req[$];
  resp_t        exp_resp[$];
  logic [127:0] mem_pay_q[$];
  bit           mem_en = 1'b0;
  int           mem_lat = 0;
  int           mem_cnt = 0;

  off_core_access_arbiter #(
    .ADDR_WIDTH    (64),
    .DATA_WIDTH    (128),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_in                    (clk),
    .reset_in                  (reset_in),
    .inst_addr_in              (inst_addr_in),
    .inst_addr_valid_in        (inst_addr_valid_in),
    .inst_payload_out          (inst_payload_out),
    .inst_ready_out            (inst_ready_out),
    .data_addr_in              (data_addr_in),
    .data_addr_valid_in        (data_addr_valid_in),
    .data_is_write_in          (data_is_write_in),
    .data_write_payload_in     (data_write_payload_in),
    .data_payload_out          (data_payload_out),
    .data_ready_out            (data_ready_out),
    .off_core_addr_out         (off_core_addr_out),
    .off_core_addr_valid_out   (off_core_addr_valid_out),
    .off_core_is_write_out     (off_core_is_write_out),
    .off_core_write_payload_out(off_core_write_payload_out),
    .off_core_payload_in       (off_core_payload_in),
    .off_core_ready_in         (off_core_ready_in),
    .timeout_error_out         (timeout_error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input int which, input string name);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      case (which)
        0:       seen = inst_ready_out;
        1:       seen = data_ready_out;
        default: seen = off_core_addr_valid_out;
      endcase
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: timed out after %0d cycles, expected event", name, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr_valid"}, 128'(off_core_addr_valid_out), 128'd0);
    check({tag, "_is_write"}, 128'(off_core_is_write_out), 128'd0);
    check({tag, "_addr"}, 128'(off_core_addr_out), 128'd0);
    check({tag, "_wpay"}, off_core_write_payload_out, 128'd0);
    check({tag, "_inst_pay"}, inst_payload_out, 128'd0);
    check({tag, "_data_pay"}, data_payload_out, 128'd0);
    check({tag, "_readies"}, {126'd0, inst_ready_out, data_ready_out}, 128'd0);
    check({tag, "_timeout"}, 128'(timeout_error_out), 128'd0);
  endtask

  // Memory model: answers mem_lat cycles into WAIT with the next queued payload.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (off_core_addr_valid_out) begin
          if (mem_cnt == mem_lat) begin
            off_core_ready_in   = 1'b1;
            off_core_payload_in = (mem_pay_q.size() > 0) ? mem_pay_q.pop_front() : '0;
          end else begin
            mem_cnt++;
          end
        end else begin
          off_core_ready_in = 1'b0;
          mem_cnt = 0;
        end
      end
    end
  end

  // Request monitor: new request on valid rise, then held fields checked every WAIT cycle.
  initial begin
    logic prev_av = 1'b0;
    req_t cur = '{addr: '0, w: 1'b0, wp: '0};
    forever begin
      @(negedge clk);
      if (off_core_addr_valid_out && !prev_av) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got addr %0h expected no request", off_core_addr_out);
        end else begin
          cur = exp_req.pop_front();
        end
      end
      if (off_core_addr_valid_out) begin
        check("req_addr", 128'(off_core_addr_out), 128'(cur.addr));
        check("req_is_write", 128'(off_core_is_write_out), 128'(cur.w));
        if (cur.w) check("req_wpay", off_core_write_payload_out, cur.wp);
      end
      prev_av = off_core_addr_valid_out;
    end
  end

  // Response monitor: every ready strobe must match the head of the expected queue.
  initial begin
    logic  prev_rdy = 1'b0;
    resp_t e;
    forever begin
      @(negedge clk);
      if (inst_ready_out || data_ready_out) begin
        if (inst_ready_out) inst_seen++;
        if (data_ready_out) data_seen++;
        check("ready_one_cycle", 128'(prev_rdy), 128'd0);
        check("ready_exclusive", 128'(inst_ready_out && data_ready_out), 128'd0);
        if (exp_resp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got inst=%0b data=%0b expected no ready",
                   inst_ready_out, data_ready_out);
        end else begin
          e = exp_resp.pop_front();
          check("resp_who", 128'(data_ready_out), 128'(e.is_data));
          check("resp_payload", e.is_data ? data_payload_out : inst_payload_out, e.pay);
        end
      end
      prev_rdy = inst_ready_out || data_ready_out;
    end
  end

  initial begin
    int i0, d0, wc;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 reset_in = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Single instruction read, memory answers 2 cycles into WAIT
    mem_en = 1'b1;
    mem_lat = 2;
    @(posedge clk);
    #1;
    mem_pay_q.push_back(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    exp_req.push_back('{addr: 64'h1000, w: 1'b0, wp: '0});
    exp_resp.push_back('{is_data: 1'b0, pay: 128'h1111_2222_3333_4444_5555_6666_7777_8888});
    inst_addr_in = 64'h1000;
    inst_addr_valid_in = 1'b1;
    wait_for(0, "inst_read_ready");
    @(posedge clk);
    #1 inst_addr_valid_in = 1'b0;

    // Data write
    mem_lat = 1;
    mem_pay_q.push_back(128'h55);
    exp_req.push_back('{addr: 64'h2040, w: 1'b1, wp: 128'hDEADBEEF});
    exp_resp.push_back('{is_data: 1'b1, pay: 128'h55});
    data_addr_in = 64'h2040;
    data_is_write_in = 1'b1;
    data_write_payload_in = 128'hDEADBEEF;
    data_addr_valid_in = 1'b1;
    wait_for(1, "data_write_ready");
    @(posedge clk);
    #1;
    data_addr_valid_in = 1'b0;
    data_is_write_in = 1'b0;

    // Round-robin tie out of reset: inst, data, inst, data
    reset_in = 1'b1;
    @(posedge clk);
    #1 reset_in = 1'b0;
    mem_lat = 0;
    i0 = inst_seen;
    d0 = data_seen;
    mem_pay_q.push_back(128'hA1);
    mem_pay_q.push_back(128'hD1);
    mem_pay_q.push_back(128'hA2);
    mem_pay_q.push_back(128'hD2);
    exp_req.push_back('{addr: 64'h100, w: 1'b0, wp: '0});
    exp_req.push_back('{addr: 64'h200, w: 1'b0, wp: '0});
    exp_req.push_back('{addr: 64'h100, w: 1'b0, wp: '0});
    exp_req.push_back('{addr: 64'h200, w: 1'b0, wp: '0});
    exp_resp.push_back('{is_data: 1'b0, pay: 128'hA1});
    exp_resp.push_back('{is_data: 1'b1, pay: 128'hD1});
    exp_resp.push_back('{is_data: 1'b0, pay: 128'hA2});
    exp_resp.push_back('{is_data: 1'b1, pay: 128'hD2});
    inst_addr_in = 64'h100;
    data_addr_in = 64'h200;
    inst_addr_valid_in = 1'b1;
    data_addr_valid_in = 1'b1;
    fork
      begin
        wait_for(0, "tie_inst_1");
        wait_for(0, "tie_inst_2");
        @(posedge clk);
        #1 inst_addr_valid_in = 1'b0;
      end
      begin
        wait_for(1, "tie_data_1");
        wait_for(1, "tie_data_2");
        @(posedge clk);
        #1 data_addr_valid_in = 1'b0;
      end
    join
    check("tie_inst_count", 128'(inst_seen - i0), 128'd2);
    check("tie_data_count", 128'(data_seen - d0), 128'd2);

    // Memory ready while idle is ignored; a request under held ready waits one cycle
    mem_en = 1'b0;
    @(posedge clk);
    #1;
    off_core_ready_in = 1'b1;
    off_core_payload_in = 128'hBEEF_0001;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready_no_wait", 128'(off_core_addr_valid_out), 128'd0);
    end
    @(posedge clk);
    #1;
    exp_req.push_back('{addr: 64'h3000, w: 1'b0, wp: '0});
    exp_resp.push_back('{is_data: 1'b0, pay: 128'hBEEF_0001});
    inst_addr_in = 64'h3000;
    inst_addr_valid_in = 1'b1;
    wc = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (off_core_addr_valid_out) wc++;
      if (inst_ready_out) break;
    end
    check("held_ready_wait_len", 128'(wc), 128'd1);
    @(posedge clk);
    #1;
    inst_addr_valid_in = 1'b0;
    off_core_ready_in = 1'b0;

    // Watchdog with TIMEOUT_CYCLES=8
    exp_req.push_back('{addr: 64'h4000, w: 1'b0, wp: '0});
    exp_resp.push_back('{is_data: 1'b1, pay: 128'h77});
    data_addr_in = 64'h4000;
    data_addr_valid_in = 1'b1;
    wait_for(2, "wdog_enter_wait");
    repeat (7) @(negedge clk);
    check("wdog_clear_at_8", 128'(timeout_error_out), 128'd0);
    @(negedge clk);
    check("wdog_set_after_8", 128'(timeout_error_out), 128'd1);
    repeat (5) @(negedge clk);
    check("wdog_still_waiting", 128'(off_core_addr_valid_out), 128'd1);
    @(posedge clk);
    #1;
    off_core_ready_in = 1'b1;
    off_core_payload_in = 128'h77;
    @(posedge clk);
    #1 off_core_ready_in = 1'b0;
    wait_for(1, "wdog_late_ready");
    @(posedge clk);
    #1 data_addr_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    check("wdog_sticky", 128'(timeout_error_out), 128'd1);
    @(posedge clk);
    #1 reset_in = 1'b1;
    @(posedge clk);
    #1 reset_in = 1'b0;
    @(negedge clk);
    check("wdog_cleared_by_reset", 128'(timeout_error_out), 128'd0);

    // Reset during WAIT drops the request and discards the late response
    exp_req.push_back('{addr: 64'h5000, w: 1'b0, wp: '0});
    inst_addr_in = 64'h5000;
    inst_addr_valid_in = 1'b1;
    wait_for(2, "midrst_enter_wait");
    reset_in = 1'b1;
    @(posedge clk);
    #1;
    reset_in = 1'b0;
    inst_addr_valid_in = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    i0 = inst_seen;
    d0 = data_seen;
    @(posedge clk);
    #1;
    off_core_ready_in = 1'b1;
    off_core_payload_in = 128'h99;
    @(posedge clk);
    #1 off_core_ready_in = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_ready", 128'((inst_seen - i0) + (data_seen - d0)), 128'd0);

    check("exp_resp_drained", 128'(exp_resp.size()), 128'd0);
    check("exp_req_drained", 128'(exp_req.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
